// File: rtl/class_argmax.sv
// Streaming argmax over NUM_CLASSES scores per frame: reports the best and
// runner-up class, the best score and the registered best-minus-second margin.
module class_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int SIGNED_MODE = 0,
    localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  best_idx,
    output logic [DATA_W-1:0] best_val,
    output logic [IDX_W-1:0]  second_idx,
    output logic [DATA_W:0]   margin
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED_MODE != 0) gt = ($signed(a) > $signed(b));
        else                  gt = (a > b);
    endfunction

    // One extra bit keeps full-range signed or unsigned differences exact.
    function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] a);
        if (SIGNED_MODE != 0) ext = {a[DATA_W-1], a};
        else                  ext = {1'b0, a};
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bval_q, bval_d, sval_q, sval_d;
    logic [IDX_W-1:0]  bidx_q, bidx_d, sidx_q, sidx_d;
    logic              svld_q, svld_d;
    logic              rdy_q, rdy_d, ov_q, ov_d;
    logic [IDX_W-1:0]  obidx_q, obidx_d, osidx_q, osidx_d;
    logic [DATA_W-1:0] obval_q, obval_d;
    logic [DATA_W:0]   omar_q, omar_d;

    logic              accept_s;
    logic [DATA_W-1:0] nbval_s, nsval_s;
    logic [IDX_W-1:0]  nbidx_s, nsidx_s;

    assign accept_s = s_valid & rdy_q;

    // Running best/second after folding in the current beat (ACCUM rule).
    always_comb begin
        nbval_s = bval_q;
        nbidx_s = bidx_q;
        nsval_s = sval_q;
        nsidx_s = sidx_q;
        if (gt(s_data, bval_q)) begin
            nbval_s = s_data;
            nbidx_s = cnt_q;
            nsval_s = bval_q;
            nsidx_s = bidx_q;
        end else if (!svld_q || gt(s_data, sval_q)) begin
            nsval_s = s_data;
            nsidx_s = cnt_q;
        end else begin
            nsval_s = sval_q;
        end
    end

    // Next-state and datapath control; clear overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bval_d  = bval_q;
        bidx_d  = bidx_q;
        sval_d  = sval_q;
        sidx_d  = sidx_q;
        svld_d  = svld_q;
        ov_d    = ov_q;
        obidx_d = obidx_q;
        obval_d = obval_q;
        osidx_d = osidx_q;
        omar_d  = omar_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    bval_d  = s_data;
                    bidx_d  = {IDX_W{1'b0}};
                    svld_d  = 1'b0;
                    cnt_d   = IDX_W'(1);
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    bval_d = nbval_s;
                    bidx_d = nbidx_s;
                    sval_d = nsval_s;
                    sidx_d = nsidx_s;
                    svld_d = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = {IDX_W{1'b0}};
                        state_d = HOLD;
                        ov_d    = 1'b1;
                        obidx_d = nbidx_s;
                        obval_d = nbval_s;
                        osidx_d = nsidx_s;
                        omar_d  = ext(nbval_s) - ext(nsval_s);
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {IDX_W{1'b0}};
                ov_d    = 1'b0;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
            cnt_d   = {IDX_W{1'b0}};
            ov_d    = 1'b0;
            svld_d  = 1'b0;
        end else begin
            svld_d = svld_d;
        end
        rdy_d = (state_d != HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= {IDX_W{1'b0}};
            bval_q  <= {DATA_W{1'b0}};
            bidx_q  <= {IDX_W{1'b0}};
            sval_q  <= {DATA_W{1'b0}};
            sidx_q  <= {IDX_W{1'b0}};
            svld_q  <= 1'b0;
            rdy_q   <= 1'b1;
            ov_q    <= 1'b0;
            obidx_q <= {IDX_W{1'b0}};
            obval_q <= {DATA_W{1'b0}};
            osidx_q <= {IDX_W{1'b0}};
            omar_q  <= {(DATA_W+1){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bval_q  <= bval_d;
            bidx_q  <= bidx_d;
            sval_q  <= sval_d;
            sidx_q  <= sidx_d;
            svld_q  <= svld_d;
            rdy_q   <= rdy_d;
            ov_q    <= ov_d;
            obidx_q <= obidx_d;
            obval_q <= obval_d;
            osidx_q <= osidx_d;
            omar_q  <= omar_d;
        end
    end

    assign s_ready    = rdy_q;
    assign out_valid  = ov_q;
    assign best_idx   = obidx_q;
    assign best_val   = obval_q;
    assign second_idx = osidx_q;
    assign margin     = omar_q;

endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax: an unsigned and a signed instance share
// one stimulus stream; expected results are hand-computed per frame.
module tb_class_argmax;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        out_ready = 1'b0;

    logic        u_rdy, u_ov, s_rdy, s_ov;
    logic [3:0]  u_bidx, u_sidx, s_bidx, s_sidx;
    logic [15:0] u_bval, s_bval;
    logic [16:0] u_mar, s_mar;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] f1 [10];
    logic [15:0] f2 [10];
    logic [15:0] f3 [10];
    logic [15:0] f4 [10];
    logic [15:0] f5 [10];

    always #5 clk = ~clk;

    class_argmax #(.NUM_CLASSES(10), .DATA_W(16), .SIGNED_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(u_rdy),
        .s_data(s_data), .out_valid(u_ov), .out_ready(out_ready),
        .best_idx(u_bidx), .best_val(u_bval), .second_idx(u_sidx), .margin(u_mar)
    );

    class_argmax #(.NUM_CLASSES(10), .DATA_W(16), .SIGNED_MODE(1)) s_dut (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(s_rdy),
        .s_data(s_data), .out_valid(s_ov), .out_ready(out_ready),
        .best_idx(s_bidx), .best_val(s_bval), .second_idx(s_sidx), .margin(s_mar)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input bit sgn, input logic [3:0] e_bidx,
                             input logic [15:0] e_bval, input logic [3:0] e_sidx,
                             input logic [16:0] e_mar);
        if (sgn) begin
            chk({tag, " s.best_idx"}, 32'(s_bidx), 32'(e_bidx));
            chk({tag, " s.best_val"}, 32'(s_bval), 32'(e_bval));
            chk({tag, " s.second_idx"}, 32'(s_sidx), 32'(e_sidx));
            chk({tag, " s.margin"}, 32'(s_mar), 32'(e_mar));
        end else begin
            chk({tag, " u.best_idx"}, 32'(u_bidx), 32'(e_bidx));
            chk({tag, " u.best_val"}, 32'(u_bval), 32'(e_bval));
            chk({tag, " u.second_idx"}, 32'(u_sidx), 32'(e_sidx));
            chk({tag, " u.margin"}, 32'(u_mar), 32'(e_mar));
        end
    endtask

    // Drives a frame on falling edges; optional random bubbles and clear on the last beat.
    task automatic send_frame(input string tag, input logic [15:0] v [10],
                              input bit bub, input bit clr_last);
        for (int i = 0; i < 10; i++) begin
            if (bub) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                end
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = v[i];
            clear   = (clr_last && i == 9);
        end
        @(negedge clk);
        s_valid = 1'b0;
        clear   = 1'b0;
        chk({tag, " u.out_valid"}, 32'(u_ov), clr_last ? 32'd0 : 32'd1);
        chk({tag, " s.out_valid"}, 32'(s_ov), clr_last ? 32'd0 : 32'd1);
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " rel out_valid"}, 32'(u_ov), 32'd0);
        chk({tag, " rel s_ready"}, 32'(u_rdy), 32'd1);
    endtask

    initial begin
        f1 = '{16'd3, 16'd9, 16'd1, 16'd7, 16'd0, 16'd2, 16'd8, 16'd4, 16'd5, 16'd6};
        f2 = '{default: 16'h0100};
        f3 = '{16'hFFFF, 16'h8000, 16'hFFFE, 16'h8000, 16'h8000,
               16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        f4 = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        f5 = '{16'h0010, 16'h0020, 16'h0005, 16'h0030, 16'h0030,
               16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h002F};

        #1;
        chk("reset out_valid", 32'(u_ov), 32'd0);
        check_res("reset", 1'b0, 4'd0, 16'h0000, 4'd0, 17'h00000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset s_ready", 32'(u_rdy), 32'd1);

        send_frame("f1", f1, 1'b0, 1'b0);
        check_res("f1", 1'b0, 4'd1, 16'd9, 4'd6, 17'd1);
        check_res("f1", 1'b1, 4'd1, 16'd9, 4'd6, 17'd1);

        // Hold for 5 cycles with s_valid high; handoff cycle must not accept a beat.
        s_valid = 1'b1;
        s_data  = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold s_ready", 32'(u_rdy), 32'd0);
            chk("hold out_valid", 32'(u_ov), 32'd1);
            chk("hold best_idx", 32'(u_bidx), 32'd1);
            chk("hold margin", 32'(u_mar), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        s_valid   = 1'b0;
        chk("handoff out_valid", 32'(u_ov), 32'd0);

        send_frame("f1b", f1, 1'b1, 1'b0);
        check_res("f1b", 1'b0, 4'd1, 16'd9, 4'd6, 17'd1);
        release_res("f1b");

        send_frame("f2", f2, 1'b0, 1'b0);
        check_res("f2", 1'b0, 4'd0, 16'h0100, 4'd1, 17'd0);
        release_res("f2");

        send_frame("f3", f3, 1'b1, 1'b0);
        check_res("f3", 1'b1, 4'd0, 16'hFFFF, 4'd2, 17'd1);
        check_res("f3", 1'b0, 4'd0, 16'hFFFF, 4'd2, 17'd1);
        release_res("f3");

        send_frame("f4", f4, 1'b0, 1'b0);
        check_res("f4", 1'b0, 4'd1, 16'hFFFF, 4'd0, 17'h0FFFF);
        check_res("f4", 1'b1, 4'd0, 16'h0000, 4'd2, 17'd0);
        release_res("f4");

        send_frame("f5", f5, 1'b1, 1'b0);
        check_res("f5", 1'b0, 4'd3, 16'h0030, 4'd4, 17'd0);
        release_res("f5");

        // Reset after four beats of a frame wipes outputs immediately.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = f5[i];
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check_res("midrst", 1'b0, 4'd0, 16'h0000, 4'd0, 17'd0);
        chk("midrst out_valid", 32'(u_ov), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_frame("postrst", f1, 1'b0, 1'b0);
        check_res("postrst", 1'b0, 4'd1, 16'd9, 4'd6, 17'd1);
        release_res("postrst");

        // Clear on the final beat: no result; the following frame starts clean.
        send_frame("clr", f2, 1'b0, 1'b1);
        chk("clr s_ready", 32'(u_rdy), 32'd1);
        send_frame("postclr", f5, 1'b0, 1'b0);
        check_res("postclr", 1'b0, 4'd3, 16'h0030, 4'd4, 17'd0);
        release_res("postclr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
